// File: rtl/mux_nto1_rr.sv
// N-channel registered stream mux with per-channel valid/ready handshakes,
// selectable between an external fixed select and round-robin arbitration.
module mux_nto1_rr #(
    parameter int unsigned N_CH   = 4,
    parameter int unsigned DATA_W = 8,
    localparam int unsigned SEL_W = (N_CH > 2) ? $clog2(N_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    input  logic [N_CH*DATA_W-1:0]   in_data,
    input  logic [N_CH-1:0]          in_valid,
    output logic [N_CH-1:0]          in_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SEL_W-1:0]         out_ch
);

    logic [SEL_W-1:0]  rr_ptr;
    logic [SEL_W-1:0]  rr_idx;
    logic              rr_found;
    logic [SEL_W-1:0]  cand;
    logic              cand_found;
    logic              load_en;
    logic              xfer;
    logic [DATA_W-1:0] cand_data;
    int unsigned       idx;

    // Scan rr_ptr+1 .. rr_ptr+N_CH; the single conditional subtract stands in
    // for a modulo since rr_ptr < N_CH keeps the sum below 2*N_CH.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        idx      = 0;
        for (int unsigned off = 1; off <= N_CH; off++) begin
            idx = 32'(rr_ptr) + off;
            if (idx >= N_CH) begin
                idx = idx - N_CH;
            end
            if (!rr_found && in_valid[idx[SEL_W-1:0]]) begin
                rr_found = 1'b1;
                rr_idx   = idx[SEL_W-1:0];
            end
        end
    end

    always_comb begin
        load_en    = !out_valid || out_ready;
        cand       = mode ? rr_idx : sel;
        cand_found = mode ? rr_found : (32'(sel) < N_CH);
        in_ready   = '0;
        if (cand_found && load_en) begin
            in_ready[cand] = 1'b1;
        end
        xfer = cand_found && load_en && in_valid[cand];
    end

    always_comb begin
        cand_data = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (cand == SEL_W'(k)) begin
                cand_data = in_data[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            rr_ptr    <= SEL_W'(N_CH - 1);
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= cand_data;
            out_ch    <= cand;
            if (mode) begin
                rr_ptr <= cand;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_nto1_rr.sv
// Directed bench for mux_nto1_rr: reset, round-robin order, fixed sweep,
// backpressure and out-of-range select across three parameterisations.
module tb_mux_nto1_rr;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    // Instance A: N_CH=4, DATA_W=8
    logic        mode_a;
    logic [1:0]  sel_a;
    logic [31:0] data_a;
    logic [3:0]  valid_a;
    logic [3:0]  ready_a;
    logic [7:0]  odata_a;
    logic        ovalid_a;
    logic        oready_a;
    logic [1:0]  och_a;

    // Instance B: N_CH=4, DATA_W=1
    logic        mode_b;
    logic [1:0]  sel_b;
    logic [3:0]  data_b;
    logic [3:0]  valid_b;
    logic [3:0]  ready_b;
    logic [0:0]  odata_b;
    logic        ovalid_b;
    logic        oready_b;
    logic [1:0]  och_b;

    // Instance C: N_CH=3, DATA_W=8
    logic        mode_c;
    logic [1:0]  sel_c;
    logic [23:0] data_c;
    logic [2:0]  valid_c;
    logic [2:0]  ready_c;
    logic [7:0]  odata_c;
    logic        ovalid_c;
    logic        oready_c;
    logic [1:0]  och_c;

    logic [1:0]  exp_ch [6];
    logic [7:0]  exp_dat [6];
    logic [3:0]  onehot;

    mux_nto1_rr #(.N_CH(4), .DATA_W(8)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .mode(mode_a), .sel(sel_a),
        .in_data(data_a), .in_valid(valid_a), .in_ready(ready_a),
        .out_data(odata_a), .out_valid(ovalid_a), .out_ready(oready_a), .out_ch(och_a)
    );

    mux_nto1_rr #(.N_CH(4), .DATA_W(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .mode(mode_b), .sel(sel_b),
        .in_data(data_b), .in_valid(valid_b), .in_ready(ready_b),
        .out_data(odata_b), .out_valid(ovalid_b), .out_ready(oready_b), .out_ch(och_b)
    );

    mux_nto1_rr #(.N_CH(3), .DATA_W(8)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .mode(mode_c), .sel(sel_c),
        .in_data(data_c), .in_valid(valid_c), .in_ready(ready_c),
        .out_data(odata_c), .out_valid(ovalid_c), .out_ready(oready_c), .out_ch(och_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        mode_a = 1'b0; sel_a = 2'd0; data_a = '0; valid_a = '0; oready_a = 1'b1;
        mode_b = 1'b0; sel_b = 2'd0; data_b = '0; valid_b = '0; oready_b = 1'b1;
        mode_c = 1'b0; sel_c = 2'd0; data_c = '0; valid_c = '0; oready_c = 1'b1;

        // reset state
        step();
        step();
        check("rst_ovalid", 32'(ovalid_a), 32'h0);
        check("rst_odata",  32'(odata_a),  32'h0);
        check("rst_och",    32'(och_a),    32'h0);
        rst_n = 1'b1;
        step();

        // round-robin fairness, all channels valid, 1 beat per cycle
        exp_ch  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        exp_dat = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0, 8'hA1};
        mode_a  = 1'b1;
        valid_a = 4'b1111;
        data_a  = 32'hA3A2A1A0;
        #1;
        for (int i = 0; i < 6; i++) begin
            onehot = 4'b0001 << exp_ch[i];
            check($sformatf("rr_ready%0d", i), 32'(ready_a), 32'(onehot));
            step();
            check($sformatf("rr_och%0d", i),   32'(och_a),    32'(exp_ch[i]));
            check($sformatf("rr_odata%0d", i), 32'(odata_a),  32'(exp_dat[i]));
            check($sformatf("rr_ovalid%0d", i), 32'(ovalid_a), 32'h1);
        end

        // sparse / wrap: grant 3, then 1010 alternates 1,3,1
        valid_a = 4'b1000;
        step();
        check("sp_och_first", 32'(och_a), 32'h3);
        valid_a = 4'b1010;
        exp_ch[0] = 2'd1; exp_ch[1] = 2'd3; exp_ch[2] = 2'd1;
        exp_dat[0] = 8'hA1; exp_dat[1] = 8'hA3; exp_dat[2] = 8'hA1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("sp_och%0d", i),   32'(och_a),   32'(exp_ch[i]));
            check($sformatf("sp_odata%0d", i), 32'(odata_a), 32'(exp_dat[i]));
        end

        // backpressure: load 0x55 via fixed select, then stall three cycles
        mode_a  = 1'b0;
        sel_a   = 2'd2;
        valid_a = 4'b0100;
        data_a  = 32'h00550000;
        step();
        check("bp_load_odata", 32'(odata_a), 32'h55);
        check("bp_load_och",   32'(och_a),   32'h2);
        oready_a = 1'b0;
        mode_a   = 1'b1;
        valid_a  = 4'b1111;
        data_a   = 32'h66666666;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("bp_ready%0d", i), 32'(ready_a), 32'h0);
            step();
            check($sformatf("bp_odata%0d", i),  32'(odata_a),  32'h55);
            check($sformatf("bp_ovalid%0d", i), 32'(ovalid_a), 32'h1);
            check($sformatf("bp_och%0d", i),    32'(och_a),    32'h2);
        end
        oready_a = 1'b1;
        valid_a  = 4'b0000;
        step();
        check("drain_ovalid", 32'(ovalid_a), 32'h0);
        check("drain_odata",  32'(odata_a),  32'h55);
        check("drain_och",    32'(och_a),    32'h2);

        // pointer kept through fixed-mode transfer: last RR grant was 1
        data_a  = 32'hA3A2A1A0;
        valid_a = 4'b1111;
        #1;
        check("resume_ready", 32'(ready_a), 32'h4);
        step();
        check("resume_och",   32'(och_a),   32'h2);
        check("resume_odata", 32'(odata_a), 32'hA2);

        // asynchronous reset mid-stream
        valid_a = 4'b0000;
        rst_n   = 1'b0;
        #1;
        check("arst_ovalid", 32'(ovalid_a), 32'h0);
        check("arst_odata",  32'(odata_a),  32'h0);
        check("arst_och",    32'(och_a),    32'h0);
        step();
        rst_n   = 1'b1;
        valid_a = 4'b1111;
        #1;
        check("arst_rr_ready", 32'(ready_a), 32'h1);
        step();
        check("arst_rr_och", 32'(och_a), 32'h0);

        // fixed sweep on 1-bit data: one-hot then inverted
        mode_b  = 1'b0;
        valid_b = 4'b1111;
        for (int s = 0; s < 4; s++) begin
            sel_b  = 2'(s);
            onehot = 4'b0001 << s;
            data_b = onehot;
            #1;
            check($sformatf("fx_ready%0d", s), 32'(ready_b), 32'(onehot));
            step();
            check($sformatf("fx_hi_odata%0d", s), 32'(odata_b), 32'h1);
            check($sformatf("fx_hi_och%0d", s),   32'(och_b),   32'(s));
            data_b = ~onehot;
            step();
            check($sformatf("fx_lo_odata%0d", s), 32'(odata_b), 32'h0);
            check($sformatf("fx_lo_och%0d", s),   32'(och_b),   32'(s));
        end

        // out-of-range select on a 3-channel instance
        mode_c  = 1'b0;
        sel_c   = 2'd3;
        valid_c = 3'b111;
        data_c  = 24'h332211;
        #1;
        check("oor_ready", 32'(ready_c), 32'h0);
        step();
        check("oor_ovalid0", 32'(ovalid_c), 32'h0);
        step();
        check("oor_ovalid1", 32'(ovalid_c), 32'h0);
        sel_c = 2'd2;
        #1;
        check("c_ready_sel2", 32'(ready_c), 32'h4);
        step();
        check("c_ovalid", 32'(ovalid_c), 32'h1);
        check("c_och",    32'(och_c),    32'h2);
        check("c_odata",  32'(odata_c),  32'h33);
        // fixed-mode ready does not wait on the selected channel's valid
        valid_c = 3'b000;
        sel_c   = 2'd1;
        #1;
        check("c_ready_novalid", 32'(ready_c), 32'h2);
        step();
        check("c_drain_ovalid", 32'(ovalid_c), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
